// File: rtl/ssp_rx_fifo_if.sv
// SSP receive FIFO bus: APB read/write strobes, shifter push port and FIFO status.
interface ssp_rx_fifo_if #(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned CNT_W      = 3
);
    logic                  PSEL;
    logic                  PWRITE;
    logic [FIFO_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [FIFO_WIDTH-1:0] PRDATA;
    logic                  SSPRXINTR;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  rx_overrun;

    modport master (
        output PSEL, PWRITE, rx_data, rx_valid,
        input  PRDATA, SSPRXINTR, fifo_empty, fifo_count, rx_overrun
    );

    modport slave (
        input  PSEL, PWRITE, rx_data, rx_valid,
        output PRDATA, SSPRXINTR, fifo_empty, fifo_count, rx_overrun
    );
endinterface

// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO: buffers shifter bytes for APB reads, flags full and sticky overrun.
module ssp_rx_fifo #(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          PCLK,
    input  logic          CLEAR_B,
    ssp_rx_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_WIDTH-1:0] prdata_q, prdata_d;
    logic                  overrun_q, overrun_d;

    logic full_c;
    logic empty_c;
    logic pop_c;
    logic push_c;
    logic drop_c;

    assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);
    assign pop_c   = bus.PSEL && !bus.PWRITE && !empty_c;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_c  = bus.rx_valid && (!full_c || pop_c);
    assign drop_c  = bus.rx_valid && full_c && !pop_c;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        prdata_d  = prdata_q;
        overrun_d = overrun_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = bus.rx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop_c) begin
            prdata_d = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set takes priority over an APB write clear in the same cycle.
        if (bus.PSEL && bus.PWRITE) overrun_d = 1'b0;
        if (drop_c)                 overrun_d = 1'b1;
    end

    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            prdata_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            prdata_q  <= prdata_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.PRDATA     = prdata_q;
    assign bus.SSPRXINTR  = full_c;
    assign bus.fifo_empty = empty_c;
    assign bus.fifo_count = count_q;
    assign bus.rx_overrun = overrun_q;
endmodule

// File: tb/tb_ssp_rx_fifo.sv
// Self-checking bench for ssp_rx_fifo: directed scenarios plus random traffic vs a queue model.
module tb_ssp_rx_fifo;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 3;

    logic PCLK = 1'b0;
    logic CLEAR_B;

    ssp_rx_fifo_if #(.FIFO_WIDTH(W), .CNT_W(CW)) bus ();

    ssp_rx_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .PCLK    (PCLK),
        .CLEAR_B (CLEAR_B),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain queue of bytes, last read byte, sticky overrun.
    logic [W-1:0] q_m[$];
    logic [W-1:0] prd_m;
    logic         ovr_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, 32'(bus.fifo_count), 32'(q_m.size()));
        check({tag, ".empty"}, 32'(bus.fifo_empty), 32'(q_m.size() == 0));
        check({tag, ".intr"},  32'(bus.SSPRXINTR),  32'(q_m.size() == D));
        check({tag, ".prdata"}, 32'(bus.PRDATA),    32'(prd_m));
        check({tag, ".ovr"},   32'(bus.rx_overrun), 32'(ovr_m));
    endtask

    task automatic idle_inputs();
        bus.PSEL     = 1'b0;
        bus.PWRITE   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
    endtask

    // One clock: drive, predict from pre-edge model state, sample 1 time unit after the edge.
    task automatic cycle(input logic psel, input logic pwrite, input logic valid,
                         input logic [W-1:0] data, input string tag);
        bit pop, full, push;
        bus.PSEL     = psel;
        bus.PWRITE   = pwrite;
        bus.rx_valid = valid;
        bus.rx_data  = data;
        pop  = psel && !pwrite && (q_m.size() != 0);
        full = (q_m.size() == D);
        push = valid && (!full || pop);
        @(posedge PCLK);
        if (pop)  prd_m = q_m.pop_front();
        if (push) q_m.push_back(data);
        if (psel && pwrite)        ovr_m = 1'b0;
        if (valid && full && !pop) ovr_m = 1'b1;
        #1;
        idle_inputs();
        check_model(tag);
    endtask

    task automatic push(input logic [W-1:0] d, input string tag);
        cycle(1'b0, 1'b0, 1'b1, d, tag);
    endtask

    task automatic rd(input string tag);
        cycle(1'b1, 1'b0, 1'b0, '0, tag);
    endtask

    task automatic apb_wr(input string tag);
        cycle(1'b1, 1'b1, 1'b0, '0, tag);
    endtask

    task automatic model_reset();
        q_m.delete();
        prd_m = '0;
        ovr_m = 1'b0;
    endtask

    initial begin
        logic [W-1:0] vals [4];
        idle_inputs();
        model_reset();
        CLEAR_B = 1'b0;
        #11;
        check("por.count", 32'(bus.fifo_count), 32'd0);
        check("por.empty", 32'(bus.fifo_empty), 32'd1);
        CLEAR_B = 1'b1;

        // Async reset mid-stream with count 3, overrun set and PRDATA non-zero
        push(8'h31, "t1"); push(8'h32, "t1"); push(8'h33, "t1"); push(8'h34, "t1");
        push(8'h35, "t1.ovr");
        rd("t1.rd");
        check("t1.pre_count", 32'(bus.fifo_count), 32'd3);
        #2 CLEAR_B = 1'b0;
        #1;
        check("t1.rst_count",  32'(bus.fifo_count), 32'd0);
        check("t1.rst_empty",  32'(bus.fifo_empty), 32'd1);
        check("t1.rst_prdata", 32'(bus.PRDATA),     32'h00);
        check("t1.rst_ovr",    32'(bus.rx_overrun), 32'd0);
        check("t1.rst_intr",   32'(bus.SSPRXINTR),  32'd0);
        model_reset();
        #2 CLEAR_B = 1'b1;

        // Ordering through a full FIFO
        vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3; vals[3] = 8'hD4;
        for (int i = 0; i < 4; i++) push(vals[i], "t2.push");
        check("t2.intr", 32'(bus.SSPRXINTR), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd("t2.rd");
            check("t2.prdata", 32'(bus.PRDATA), 32'(vals[i]));
        end
        check("t2.empty", 32'(bus.fifo_empty), 32'd1);

        // Overrun keeps contents; APB write clears; set wins over clear
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), "t3.fill");
        push(8'hEE, "t3.drop");
        check("t3.ovr",   32'(bus.rx_overrun), 32'd1);
        check("t3.count", 32'(bus.fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            rd("t3.rd");
            check("t3.prdata", 32'(bus.PRDATA), 32'h60 + 32'(i));
        end
        apb_wr("t3.clr");
        check("t3.ovr_clr", 32'(bus.rx_overrun), 32'd0);
        for (int i = 0; i < 4; i++) push(8'h70 + 8'(i), "t3.fill2");
        cycle(1'b1, 1'b1, 1'b1, 8'h99, "t3.setwins");
        check("t3.setwins_ovr", 32'(bus.rx_overrun), 32'd1);
        apb_wr("t3.clr2");
        for (int i = 0; i < 4; i++) rd("t3.drain");

        // Simultaneous pop and push on a full FIFO
        push(8'h11, "t4"); push(8'h22, "t4"); push(8'h33, "t4"); push(8'h44, "t4");
        cycle(1'b1, 1'b0, 1'b1, 8'h55, "t4.both");
        check("t4.prdata", 32'(bus.PRDATA),     32'h11);
        check("t4.count",  32'(bus.fifo_count), 32'd4);
        check("t4.ovr",    32'(bus.rx_overrun), 32'd0);
        for (int i = 0; i < 3; i++) rd("t4.rd");
        rd("t4.last");
        check("t4.last_prdata", 32'(bus.PRDATA), 32'h55);

        // Empty FIFO: read ignored; push+read pushes only, no bypass
        rd("t5.empty_rd");
        check("t5.prdata_hold", 32'(bus.PRDATA),     32'h55);
        check("t5.count0",      32'(bus.fifo_count), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 8'h7E, "t5.both");
        check("t5.count1",   32'(bus.fifo_count), 32'd1);
        check("t5.no_bypass", 32'(bus.PRDATA),    32'h55);
        rd("t5.rd");
        check("t5.prdata", 32'(bus.PRDATA), 32'h7E);

        // Pointer wrap with alternating push/pop
        for (int i = 0; i < 10; i++) begin
            push(8'(i), "t6.push");
            rd("t6.rd");
            check("t6.prdata", 32'(bus.PRDATA), 32'(i));
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic ps, pw, rv;
            ps = ($urandom_range(0, 99) < 50);
            pw = ($urandom_range(0, 99) < 15);
            rv = ($urandom_range(0, 99) < 55);
            cycle(ps, pw, rv, 8'($urandom), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
